sdram_line_packer: RTL and testbench

Burst adapter between the direct-mapped cache's line-fill port and a 16-bit SDRAM controller. It accepts a cacheline fill request from the cache and issues one line-aligned 16-halfword read burst to the controller. It packs the returned halfwords into a buffer of eight 32-bit words, then replays the line to the cache as an 8-word fill stream, critical word first. The cache sees the same req/fill handshake it would see from a native 32-bit controller.

---
 rtl/sdram_line_packer.sv | 143 ++++++++++++++
 tb/tb_sdram_line_packer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_line_packer.sv
// sdram_line_packer
//
// Burst adapter between the cache line-fill port and a 16-bit SDRAM
// controller. A fill request becomes one line-aligned 16-halfword read
// burst. The returned halfwords are packed into eight 32-bit words, and
// the line is replayed to the cache critical word first, one word per
// cycle.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   cache_addr   fill address; [4:2] selects the critical word
//   cache_req    fill request level, held by the cache until cache_fill
//   cache_fill   one-cycle strobe marking the critical word on cache_data
//   cache_data   registered fill data word
//   sdr_addr     line-aligned burst start address
//   sdr_req      burst read request level, held until sdr_ack
//   sdr_ack      one-cycle accept from the controller
//   sdr_rdvalid  sdr_data carries one returned halfword this cycle
//   sdr_data     returned halfword, ascending address order from line base
//   busy         high whenever the FSM is not idle
//   state_dbg    current FSM state, for observation
//
// Handshakes: sdr_req is a level that rises the cycle after a request is
// taken and falls the cycle after sdr_ack is sampled high; sdr_ack may
// arrive on the first sdr_req cycle. sdr_rdvalid is a qualifier with no
// back-pressure, and it counts only while collecting. cache_req is a level
// sampled only in IDLE, so dropping it later never aborts a burst.

module sdram_line_packer #(
    parameter bit lowfirst = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cache_addr,
    input  logic        cache_req,
    output logic        cache_fill,
    output logic [31:0] cache_data,
    output logic [31:0] sdr_addr,
    output logic        sdr_req,
    input  logic        sdr_ack,
    input  logic        sdr_rdvalid,
    input  logic [15:0] sdr_data,
    output logic        busy,
    output logic [1:0]  state_dbg
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQ     = 2'd1;
    localparam logic [1:0] COLLECT = 2'd2;
    localparam logic [1:0] EMIT    = 2'd3;

    logic [1:0]  state;
    logic [2:0]  crit_q;      // critical word index of the latched address
    logic [3:0]  beat_cnt;    // halfword index within the burst
    logic [2:0]  emit_cnt;    // position within the 8-word replay
    logic [31:0] line_q [8];
    logic [31:0] line_n [8];
    logic        upper_sel;
    logic [2:0]  next_idx;

    // The byte offset within a word never affects a line fill.
    logic unused_addr_bits;
    assign unused_addr_bits = ^cache_addr[1:0];

    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // Even beats fill the low half when lowfirst is set, the high half otherwise.
    assign upper_sel = beat_cnt[0] ^ ~lowfirst;

    // Word replayed on the next EMIT cycle; 3-bit add wraps around the line.
    assign next_idx = crit_q + emit_cnt + 3'd1;

    // Buffer contents including the halfword arriving this cycle. Used so
    // the critical word can be launched on the same edge that stores the
    // last beat, even when that beat belongs to the critical word.
    always_comb begin
        line_n = line_q;
        if (state == COLLECT && sdr_rdvalid) begin
            if (upper_sel) begin
                line_n[beat_cnt[3:1]][31:16] = sdr_data;
            end else begin
                line_n[beat_cnt[3:1]][15:0] = sdr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            crit_q     <= 3'd0;
            beat_cnt   <= 4'd0;
            emit_cnt   <= 3'd0;
            sdr_addr   <= 32'd0;
            sdr_req    <= 1'b0;
            cache_fill <= 1'b0;
            cache_data <= 32'd0;
            line_q     <= '{default: 32'd0};
        end else begin
            case (state)
                IDLE: begin
                    if (cache_req) begin
                        crit_q   <= cache_addr[4:2];
                        sdr_addr <= {cache_addr[31:5], 5'b0};
                        sdr_req  <= 1'b1;
                        beat_cnt <= 4'd0;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (sdr_ack) begin
                        sdr_req <= 1'b0;
                        state   <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (sdr_rdvalid) begin
                        line_q   <= line_n;
                        beat_cnt <= beat_cnt + 4'd1;
                        if (beat_cnt == 4'd15) begin
                            emit_cnt   <= 3'd0;
                            cache_fill <= 1'b1;
                            cache_data <= line_n[crit_q];
                            state      <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    cache_fill <= 1'b0;
                    if (emit_cnt == 3'd7) begin
                        state <= IDLE;
                    end else begin
                        emit_cnt   <= emit_cnt + 3'd1;
                        cache_data <= line_q[next_idx];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_line_packer.sv
// Bench for sdram_line_packer. Two instances share all inputs, one per
// halfword ordering, and every line is checked on both against a
// word-level model of the packed line.

module tb_sdram_line_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cache_addr;
    logic        cache_req;
    logic        sdr_ack;
    logic        sdr_rdvalid;
    logic [15:0] sdr_data;

    logic        fill1, fill0;
    logic [31:0] data1, data0;
    logic [31:0] saddr1, saddr0;
    logic        sreq1, sreq0;
    logic        busy1, busy0;
    logic [1:0]  st1, st0;

    always #5 clk = ~clk;

    sdram_line_packer #(.lowfirst(1'b1)) dut1 (
        .clk(clk), .reset(reset), .cache_addr(cache_addr), .cache_req(cache_req),
        .cache_fill(fill1), .cache_data(data1), .sdr_addr(saddr1), .sdr_req(sreq1),
        .sdr_ack(sdr_ack), .sdr_rdvalid(sdr_rdvalid), .sdr_data(sdr_data),
        .busy(busy1), .state_dbg(st1)
    );

    sdram_line_packer #(.lowfirst(1'b0)) dut0 (
        .clk(clk), .reset(reset), .cache_addr(cache_addr), .cache_req(cache_req),
        .cache_fill(fill0), .cache_data(data0), .sdr_addr(saddr0), .sdr_req(sreq0),
        .sdr_ack(sdr_ack), .sdr_rdvalid(sdr_rdvalid), .sdr_data(sdr_data),
        .busy(busy0), .state_dbg(st0)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int lines_done = 0;
    int fill_cnt1 = 0;
    int fill_cnt0 = 0;

    logic [31:0] exp_q1[$];
    logic [31:0] exp_q0[$];
    logic [15:0] beats [16];
    logic [31:0] first_word1;

    always @(posedge clk) begin
        if (fill1) fill_cnt1++;
        if (fill0) fill_cnt0++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Line model: pair halfwords into words, then rotate to the critical word.
    task automatic model_line(input logic [31:0] addr);
        logic [31:0] w1 [8];
        logic [31:0] w0 [8];
        int crit;
        for (int i = 0; i < 8; i++) begin
            w1[i] = {beats[2*i+1], beats[2*i]};
            w0[i] = {beats[2*i], beats[2*i+1]};
        end
        crit = int'(addr[4:2]);
        for (int e = 0; e < 8; e++) begin
            exp_q1.push_back(w1[(crit + e) % 8]);
            exp_q0.push_back(w0[(crit + e) % 8]);
        end
    endtask

    task automatic counting_beats();
        for (int i = 0; i < 16; i++) beats[i] = 16'(i);
    endtask

    task automatic random_beats();
        for (int i = 0; i < 16; i++) beats[i] = 16'($urandom_range(0, 16'hFFFF));
    endtask

    // Runs one complete fill starting just after a falling edge.
    task automatic run_line(input logic [31:0] addr, input int ack_delay, input int max_gap,
                            input bit spurious, input bit drop_req);
        logic [31:0] e1, e0;
        model_line(addr);

        // IDLE cycle carrying the request (and possibly a stray beat)
        cache_addr  = addr;
        cache_req   = 1'b1;
        sdr_rdvalid = spurious;
        sdr_data    = 16'hDEAD;
        @(negedge clk);
        check("sdr_req_rise", sreq1, 1'b1);
        check("busy_rise", busy1, 1'b1);
        check("sdr_addr_lf1", saddr1, {addr[31:5], 5'b0});
        check("sdr_addr_lf0", saddr0, {addr[31:5], 5'b0});

        for (int d = 0; d < ack_delay; d++) begin
            sdr_ack     = 1'b0;
            sdr_rdvalid = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
            sdr_data    = 16'($urandom_range(0, 16'hFFFF));
            @(negedge clk);
            check("sdr_req_hold", sreq1, 1'b1);
        end
        sdr_ack     = 1'b1;
        sdr_rdvalid = spurious;
        sdr_data    = 16'hBEEF;
        @(negedge clk);
        sdr_ack     = 1'b0;
        sdr_rdvalid = 1'b0;
        check("sdr_req_fall", sreq1, 1'b0);

        for (int k = 0; k < 16; k++) begin
            int gap;
            if (drop_req && k == 8) cache_req = 1'b0;
            gap = $urandom_range(0, max_gap);
            repeat (gap) begin
                sdr_rdvalid = 1'b0;
                @(negedge clk);
            end
            sdr_rdvalid = 1'b1;
            sdr_data    = beats[k];
            @(negedge clk);
            if (k == 14) check("no_early_fill", fill1, 1'b0);
        end

        for (int e = 0; e < 8; e++) begin
            if (e > 0) @(negedge clk);
            sdr_rdvalid = spurious;
            sdr_data    = 16'($urandom_range(0, 16'hFFFF));
            if (e == 0) cache_req = 1'b0;
            e1 = exp_q1.pop_front();
            e0 = exp_q0.pop_front();
            if (e == 0) first_word1 = data1;
            check($sformatf("fill_lf1_e%0d", e), fill1, (e == 0));
            check($sformatf("fill_lf0_e%0d", e), fill0, (e == 0));
            check($sformatf("data_lf1_e%0d", e), data1, e1);
            check($sformatf("data_lf0_e%0d", e), data0, e0);
        end

        @(negedge clk);
        sdr_rdvalid = 1'b0;
        check("idle_busy", busy1, 1'b0);
        check("idle_fill", fill1, 1'b0);
        @(negedge clk);
        check("no_new_req", sreq1, 1'b0);
        check("no_new_req_busy", busy0, 1'b0);
        lines_done++;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sdr_req"}, {sreq1, sreq0}, 2'b00);
        check({tag, "_sdr_addr1"}, saddr1, 32'd0);
        check({tag, "_sdr_addr0"}, saddr0, 32'd0);
        check({tag, "_fill"}, {fill1, fill0}, 2'b00);
        check({tag, "_data1"}, data1, 32'd0);
        check({tag, "_data0"}, data0, 32'd0);
        check({tag, "_busy"}, {busy1, busy0}, 2'b00);
        check({tag, "_state"}, {st1, st0}, 4'd0);
    endtask

    initial begin
        reset       = 1'b0;
        cache_addr  = 32'd0;
        cache_req   = 1'b0;
        sdr_ack     = 1'b0;
        sdr_rdvalid = 1'b0;
        sdr_data    = 16'd0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        @(negedge clk);

        // basic fill, word 0 first
        counting_beats();
        run_line(32'h0000_1000, 0, 0, 1'b0, 1'b0);
        check("basic_first_word", first_word1, 32'h0001_0000);

        // critical word 7
        counting_beats();
        run_line(32'h0000_105C, 0, 0, 1'b0, 1'b0);
        check("crit_first_word", first_word1, 32'h000F_000E);

        // word 2 first; the swapped-order instance sees the halves reversed
        counting_beats();
        run_line(32'h0000_2008, 0, 0, 1'b0, 1'b0);

        // stalled controller with gaps and stray beats
        random_beats();
        run_line(32'h0000_4A34, 5, 3, 1'b1, 1'b0);

        // request dropped mid-collect
        random_beats();
        run_line(32'h0012_3418, 1, 1, 1'b0, 1'b1);

        // reset after seven beats of a burst
        cache_addr = 32'h5555_5540;
        cache_req  = 1'b1;
        @(negedge clk);
        sdr_ack = 1'b1;
        @(negedge clk);
        sdr_ack = 1'b0;
        for (int k = 0; k < 7; k++) begin
            sdr_rdvalid = 1'b1;
            sdr_data    = 16'hA500 | 16'(k);
            @(negedge clk);
        end
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        repeat (3) @(negedge clk);
        cache_req   = 1'b0;
        sdr_rdvalid = 1'b0;
        reset       = 1'b1;
        @(negedge clk);
        check("post_reset_busy", busy1, 1'b0);
        random_beats();
        run_line(32'h0000_3004, 0, 0, 1'b0, 1'b0);

        // random lines
        for (int i = 0; i < 5; i++) begin
            random_beats();
            run_line($urandom, $urandom_range(0, 4), $urandom_range(0, 2),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        check("fill_strobes_lf1", fill_cnt1, lines_done);
        check("fill_strobes_lf0", fill_cnt0, lines_done);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
